// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Pipeline MEM stage. It sits between the EX/MEM and MEM/WB registers and
// turns load/store control into a valid/ready request to the data cache. It
// then waits for the cache response and aligns and extends load data. While
// an access is outstanding it holds the upstream pipeline and MEM/WB frozen.
// It flags misaligned or illegal accesses and response timeouts.
//
// Parameters
//   DATA_W          datapath / address width (only 32 is supported)
//   TIMEOUT_CYC     cycles spent waiting for a response before bus_err_o
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   mem_read_i      EX/MEM: instruction is a load
//   mem_write_i     EX/MEM: instruction is a store
//   funct3_i        EX/MEM: RV32I access size / sign encoding
//   addr_i          EX/MEM: effective byte address
//   wdata_i         EX/MEM: store data (rs2)
//   addr_o          addr_i passed straight through to MEM/WB
//   data_o          extended load result; non-zero only in the DONE cycle
//   dcache_stall_o  freezes IF..MEM/WB while an access is outstanding
//   misalign_o      current op is misaligned or uses an illegal funct3
//   bus_err_o       one-cycle pulse when the cache response timed out
//   dc_req_*        request channel to the data cache
//   dc_rsp_*        response channel from the data cache
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              dcache_stall_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              dc_req_valid_o,
  input  logic              dc_req_ready_i,
  output logic              dc_we_o,
  output logic [DATA_W-1:0] dc_addr_o,
  output logic [DATA_W-1:0] dc_wdata_o,
  output logic [3:0]        dc_wstrb_o,
  input  logic              dc_rsp_valid_i,
  input  logic [DATA_W-1:0] dc_rsp_rdata_i
);

  // The counter has to hold values up to TIMEOUT_CYC-1.
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;

  logic                access_req;
  logic                is_byte;
  logic                is_half;
  logic                is_word;
  logic                is_unsigned;
  logic                funct3_legal;
  logic                addr_misaligned;
  logic                mem_op;
  logic                in_req;

  logic [7:0]          load_byte;
  logic [15:0]         load_half;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   lane_wdata;
  logic [3:0]          lane_wstrb;

  // -------------------------------------------------------------------------
  // funct3 decode. The unsigned variants (100/101) exist only for loads, so
  // a store with those encodings is rejected as illegal.
  // -------------------------------------------------------------------------
  always_comb begin
    is_byte      = 1'b0;
    is_half      = 1'b0;
    is_word      = 1'b0;
    is_unsigned  = 1'b0;
    funct3_legal = 1'b0;
    case (funct3_i)
      3'b000: begin
        is_byte      = 1'b1;
        funct3_legal = 1'b1;
      end
      3'b001: begin
        is_half      = 1'b1;
        funct3_legal = 1'b1;
      end
      3'b010: begin
        is_word      = 1'b1;
        funct3_legal = 1'b1;
      end
      3'b100: begin
        is_byte      = 1'b1;
        is_unsigned  = 1'b1;
        funct3_legal = mem_read_i;
      end
      3'b101: begin
        is_half      = 1'b1;
        is_unsigned  = 1'b1;
        funct3_legal = mem_read_i;
      end
      default: begin
        funct3_legal = 1'b0;
      end
    endcase
  end

  assign access_req      = mem_read_i | mem_write_i;
  assign addr_misaligned = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
  assign misalign_o      = access_req & (~funct3_legal | addr_misaligned);
  assign mem_op          = access_req & ~misalign_o;

  // -------------------------------------------------------------------------
  // Access FSM next-state logic. The timeout counter only advances in WAIT.
  // A response seen outside WAIT, including one that coincides with ready
  // in REQ, is dropped on purpose.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dc_req_ready_i) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dc_rsp_valid_i) begin
          rdata_d = dc_rsp_rdata_i;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register. bus_err is registered so that its pulse lines up with
  // the DONE cycle in which MEM/WB captures the zeroed load result.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Load alignment and extension from the latched response word. The
  // EX/MEM inputs are held while stalled, so addr_i still selects the lane.
  // -------------------------------------------------------------------------
  always_comb begin
    load_byte = 8'h00;
    case (addr_i[1:0])
      2'b00:   load_byte = rdata_q[7:0];
      2'b01:   load_byte = rdata_q[15:8];
      2'b10:   load_byte = rdata_q[23:16];
      default: load_byte = rdata_q[31:24];
    endcase
    load_half = addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
    if (is_byte) begin
      load_ext = {{24{~is_unsigned & load_byte[7]}}, load_byte};
    end else if (is_half) begin
      load_ext = {{16{~is_unsigned & load_half[15]}}, load_half};
    end else begin
      load_ext = rdata_q;
    end
  end

  // -------------------------------------------------------------------------
  // Store lane replication and byte strobes. Sub-word stores are copied into
  // every lane so the cache only needs to look at the strobes.
  // -------------------------------------------------------------------------
  always_comb begin
    if (is_byte) begin
      lane_wdata = {4{wdata_i[7:0]}};
      lane_wstrb = 4'b0001 << addr_i[1:0];
    end else if (is_half) begin
      lane_wdata = {2{wdata_i[15:0]}};
      lane_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
    end else begin
      lane_wdata = wdata_i;
      lane_wstrb = 4'b1111;
    end
  end

  // Request fields are only driven while the request is presented, so the
  // cache side sees zeros whenever nothing is being asked of it.
  assign in_req         = (state_q == ST_REQ);
  assign dc_req_valid_o = in_req;
  assign dc_we_o        = in_req & mem_write_i;
  assign dc_addr_o      = in_req ? {addr_i[DATA_W-1:2], 2'b00} : '0;
  assign dc_wdata_o     = (in_req & mem_write_i) ? lane_wdata : '0;
  assign dc_wstrb_o     = (in_req & mem_write_i) ? lane_wstrb : 4'b0000;

  // The stall drops in DONE so MEM/WB advances exactly once per access.
  assign dcache_stall_o = mem_op & (state_q != ST_DONE);
  assign addr_o         = addr_i;
  assign data_o         = ((state_q == ST_DONE) && mem_read_i) ? load_ext : '0;
  assign bus_err_o      = bus_err_q;

endmodule
